// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Generates EX forwarding selects, inserts a single bubble on load-use,
// flushes IF/ID and ID/EX on taken branches, and freezes the pipeline while
// a data-memory access is outstanding. A watchdog bounds that wait.
// Optional build macro HAZARD_PERF_CNT_EN enables the stall/flush
// performance counters. Without it the counter ports read constant 0.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_ID,
  input  logic [4:0]        rs2_ID,
  input  logic              rs2_used_ID,
  input  logic [4:0]        rs1_EX,
  input  logic [4:0]        rs2_EX,
  input  logic [4:0]        rd_EX,
  input  logic [4:0]        rd_MEM,
  input  logic [4:0]        rd_WB,
  input  logic              regwrite_EX,
  input  logic              regwrite_MEM,
  input  logic              regwrite_WB,
  input  logic              memread_EX,
  input  logic              branch_taken_EX,
  input  logic              dmem_req_MEM,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              memwb_bubble,
  output logic [1:0]        forwardA,
  output logic [1:0]        forwardB,
  output logic              mem_timeout_err,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        err_reg, err_next;
  logic [16:0] wait_sum;
  logic        wait_expired;
  logic        load_use;
  logic        mem_stall;

  // Per-operand forwarding: index 0 is rs1 (forwardA), index 1 is rs2 (forwardB).
  logic [4:0]  rs_ex [2];
  logic [1:0]  fwd_sel [2];

  assign rs_ex[0] = rs1_EX;
  assign rs_ex[1] = rs2_EX;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // EX/MEM result wins over MEM/WB; x0 is hard-wired zero and never forwarded.
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (regwrite_MEM && (rd_MEM != 5'd0) && (rd_MEM == rs_ex[gi])) begin
          fwd_sel[gi] = 2'b10;
        end else if (regwrite_WB && (rd_WB != 5'd0) && (rd_WB == rs_ex[gi])) begin
          fwd_sel[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign forwardA = rst ? 2'b00 : fwd_sel[0];
  assign forwardB = rst ? 2'b00 : fwd_sel[1];

  assign load_use  = memread_EX && regwrite_EX && (rd_EX != 5'd0) &&
                     ((rd_EX == rs1_ID) || (rs2_used_ID && (rd_EX == rs2_ID)));
  assign mem_stall = dmem_req_MEM && !dmem_ready;

  // Count of MEM_WAIT cycles including the current one; widened so it cannot wrap.
  assign wait_sum     = {1'b0, wait_cnt_reg} + 17'd1;
  assign wait_expired = (wait_sum >= 17'(MEM_TIMEOUT));

  // Next-state and pipeline control outputs, defaults first.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    err_next      = err_reg;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    idex_write    = 1'b1;
    exmem_write   = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    memwb_bubble  = 1'b0;

    if (rst) begin
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      idex_write    = 1'b0;
      exmem_write   = 1'b0;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      memwb_bubble  = 1'b1;
      state_next    = RUN;
      wait_cnt_next = 16'd0;
      err_next      = 1'b0;
    end else begin
      case (state_reg)
        RUN, LOAD_STALL: begin
          if (mem_stall) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b0;
            exmem_write   = 1'b0;
            memwb_bubble  = 1'b1;
            wait_cnt_next = 16'd0;
            state_next    = MEM_WAIT;
          end else if (branch_taken_EX) begin
            // Target loads into the PC; both younger instructions are squashed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_next = RUN;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            // A second load-use right after the bubble still stalls, but the
            // controller does not chain LOAD_STALL states.
            state_next = (state_reg == RUN) ? LOAD_STALL : RUN;
          end else begin
            state_next = RUN;
          end
        end

        MEM_WAIT: begin
          if (dmem_ready) begin
            // Normal release: default outputs advance every register.
            state_next = RUN;
          end else if (wait_expired) begin
            // Watchdog: give up on the access and let the pipeline move.
            err_next      = 1'b1;
            wait_cnt_next = wait_sum[15:0];
            state_next    = RUN;
          end else begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b0;
            exmem_write   = 1'b0;
            memwb_bubble  = 1'b1;
            wait_cnt_next = wait_sum[15:0];
          end
        end

        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // State, wait counter and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 16'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign mem_timeout_err = err_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_reg;
  logic [PERF_W-1:0] flush_cnt_reg;
  logic              flush_event;

  // A taken-branch flush happens only outside MEM_WAIT and when no memory stall overrides it.
  assign flush_event = !rst && (state_reg != MEM_WAIT) && !mem_stall && branch_taken_EX;

  // Performance counters, wrapping naturally at 2^PERF_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_write) begin
        stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
      end
      if (flush_event) begin
        flush_cnt_reg <= flush_cnt_reg + PERF_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
